// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and sizing constants.
package mdu_pkg;

    localparam int unsigned MDU_DATA_W = 32;
    localparam int unsigned ITERS      = MDU_DATA_W;
    localparam int unsigned CNT_W      = 6;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, writing HI/LO.
// Signed ops run on magnitudes; signs are reapplied in FINISH.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_W = MDU_DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    localparam int unsigned W2 = 2 * DATA_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_q, div_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              sgn_a, sgn_b;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   sub_diff;
    logic [W2-1:0]     prod_neg;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
        return n ? ('0 - v) : v;
    endfunction

    assign sgn_a    = bus.op[0] & bus.rs_data[DATA_W-1];
    assign sgn_b    = bus.op[0] & bus.rt_data[DATA_W-1];
    assign add_sum  = {1'b0, acc_q[W2-1:DATA_W]} + {1'b0, opb_q};
    // Remainder shifted left by one, compared against the divisor at DATA_W+1 bits
    assign sub_diff = acc_q[W2-1:DATA_W-1] - {1'b0, opb_q};
    assign prod_neg = '0 - acc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            opb_q   <= '0;
            rs_q    <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            opb_q   <= opb_d;
            rs_q    <= rs_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        opb_d   = opb_q;
        rs_d    = rs_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    div_d   = bus.op[1];
                    rs_d    = bus.rs_data;
                    opb_d   = neg_if(bus.rt_data, sgn_b);
                    acc_d   = {{DATA_W{1'b0}}, neg_if(bus.rs_data, sgn_a)};
                    neg_d   = sgn_a ^ sgn_b;
                    rneg_d  = sgn_a;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (div_q) begin
                    if (!sub_diff[DATA_W]) acc_d = {sub_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    else                   acc_d = {acc_q[W2-2:0], 1'b0};
                end else begin
                    if (acc_q[0]) acc_d = {add_sum, acc_q[DATA_W-1:1]};
                    else          acc_d = {1'b0, acc_q[W2-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FINISH;
            end
            FINISH: begin
                if (!div_q) begin
                    {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
                end else if (opb_q == '0) begin
                    hi_d  = rs_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = neg_if(acc_q[DATA_W-1:0], neg_q);
                    hi_d = neg_if(acc_q[W2-1:DATA_W], rneg_q);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic reference model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    logic chk_en;

    mult_div_unit_if #(.DATA_W(32)) bus ();

    mult_div_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions
    function automatic void model_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] h, output logic [31:0] l, output logic z);
        longint sa, sb, q, r;
        logic [63:0] p;
        z = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                h = p[63:32]; l = p[31:0];
            end
            OP_MULT: begin
                p = 64'(sa * sb);
                h = p[63:32]; l = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF; z = 1'b1;
                end else if (op == OP_DIVU) begin
                    l = a / b; h = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end
            end
        endcase
    endfunction

    // Cycle-level expectation: idle accepts writes/start, result lands 33 edges after start
    logic        m_busy, m_done, m_dbz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_dbz;
    int          rem;

    always @(posedge clk) begin
        logic [31:0] th, tl;
        logic        tz;
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_hi <= '0; m_lo <= '0; rem <= 0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (rem == 0) begin
                if (bus.hi_we) m_hi <= bus.wdata;
                if (bus.lo_we) m_lo <= bus.wdata;
                if (bus.start) begin
                    model_calc(bus.op, bus.rs_data, bus.rt_data, th, tl, tz);
                    p_hi <= th; p_lo <= tl; p_dbz <= tz;
                    rem <= ITERS + 1;
                    m_busy <= 1'b1;
                end
            end else begin
                rem <= rem - 1;
                if (rem == 1) begin
                    m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz;
                    m_done <= 1'b1; m_busy <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
            chk("cyc_done", 32'(bus.done), 32'(m_done));
            chk("cyc_dbz",  32'(bus.div_by_zero), 32'(m_dbz));
            chk("cyc_hi",   bus.hi, m_hi);
            chk("cyc_lo",   bus.lo, m_lo);
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Counts edges until done is seen; b32 records busy after the 32nd edge
    task automatic wait_done(output int n, output logic b32);
        n = 0;
        b32 = 1'b0;
        while (!bus.done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (n == 32) b32 = bus.busy;
        end
        if (!bus.done) begin
            n_chk++; n_err++;
            $display("FAIL done_timeout: got no done expected done within 60 edges");
        end
    endtask

    initial begin
        int   n;
        logic b32;
        n_chk = 0; n_err = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk_en = 1'b1;

        // 1: MULTU max*max, latency and busy window
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t1_busy_e0", 32'(bus.busy), 32'd1);
        wait_done(n, b32);
        chk("t1_latency", 32'(n), 32'd33);
        chk("t1_busy_e32", 32'(b32), 32'd1);
        chk("t1_busy_e33", 32'(bus.busy), 32'd0);
        chk("t1_hi", bus.hi, 32'hFFFF_FFFE);
        chk("t1_lo", bus.lo, 32'h0000_0001);
        @(posedge clk); #1;
        chk("t1_done_drop", 32'(bus.done), 32'd0);

        // 2: signed multiply and signed divide
        start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(n, b32);
        chk("t2_mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("t2_mult_lo", bus.lo, 32'hFFFF_FFEB);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, b32);
        chk("t2_div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("t2_div_hi", bus.hi, 32'hFFFF_FFFF);

        // 3: divide by zero, then signed overflow
        start_op(OP_DIVU, 32'd100, 32'd0);
        wait_done(n, b32);
        chk("t3_dbz_latency", 32'(n), 32'd33);
        chk("t3_dbz_hi", bus.hi, 32'd100);
        chk("t3_dbz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("t3_dbz_flag", 32'(bus.div_by_zero), 32'd1);
        @(posedge clk); #1;
        chk("t3_dbz_clear", 32'(bus.div_by_zero), 32'd0);
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, b32);
        chk("t3_ovf_lo", bus.lo, 32'h8000_0000);
        chk("t3_ovf_hi", bus.hi, 32'h0000_0000);
        chk("t3_ovf_flag", 32'(bus.div_by_zero), 32'd0);

        // 4: start while busy is ignored
        start_op(OP_MULTU, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd1000; bus.rt_data = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n, b32);
        chk("t4_latency", 32'(n), 32'd23);
        chk("t4_hi", bus.hi, 32'd0);
        chk("t4_lo", bus.lo, 32'd15);
        repeat (40) @(posedge clk);
        #1;
        chk("t4_no_second_busy", 32'(bus.busy), 32'd0);

        // 5: direct HI/LO writes
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        chk("t5_mthi", bus.hi, 32'h1234);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'd6; bus.rt_data = 32'd7;
        bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.lo_we = 1'b0;
        chk("t5_mtlo_start", bus.lo, 32'hABCD);
        repeat (4) @(posedge clk);
        #1;
        bus.hi_we = 1'b1; bus.wdata = 32'h5555;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        chk("t5_mthi_busy", bus.hi, 32'h1234);
        wait_done(n, b32);
        chk("t5_res_hi", bus.hi, 32'd0);
        chk("t5_res_lo", bus.lo, 32'd42);

        // 6: reset mid-operation
        start_op(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_hi", bus.hi, 32'd0);
        chk("t6_lo", bus.lo, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        start_op(OP_MULTU, 32'd2, 32'd2);
        wait_done(n, b32);
        chk("t6_after_lo", bus.lo, 32'd4);
        chk("t6_after_hi", bus.hi, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two register read operands (rs, rt) and computes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, into architectural HI/LO registers. HI/LO are also writable directly (MTHI/MTLO) and are read combinationally (MFHI/MFLO). The control unit stalls dependent HI/LO reads while busy is high.

Parameters:
DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset
start  input  1  begin operation; sampled only when idle
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_data  input  DATA_W  multiplicand / dividend (register file ReadData1)
rt_data  input  DATA_W  multiplier / divisor (register file ReadData2)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  DATA_W  MTHI/MTLO write data
busy  output  1  operation in progress
done  output  1  single-cycle pulse; HI/LO hold the new result
div_by_zero  output  1  valid with done; divisor was zero
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register

Behaviour:
- Reset: reset=0 at a posedge clears state to IDLE and clears the counter, hi, lo, busy, done and div_by_zero. Reset mid-operation aborts the operation, and no done is produced.
- FSM has three states: IDLE, CALC, FINISH.
- IDLE with start=1 at edge E0:
  - Latch operands.
  - For signed ops, latch |rs| and |rt| plus both sign bits.
  - Clear the 6-bit counter and go to CALC. busy=1 after E0.
- CALC, edges E1..E32, one iteration per edge:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing one quotient bit per edge.
  - After the edge where counter==DATA_W-1, go to FINISH.
- FINISH, edge E33:
  - Apply sign correction and write hi/lo.
  - done=1 and busy=0 after E33, then return to IDLE.
  - done drops after E34.
  - Latency from the start edge to the done cycle is 33 edges.
- Multiply result: {hi,lo} = 64-bit product. For MULT the product is negated when sign(rs)^sign(rt).
- Divide result: lo = quotient, hi = remainder, truncating toward zero.
  - Quotient is negative when the signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (rt=0, DIV or DIVU):
  - Full latency still applies.
  - hi=rs_data as latched, lo=32'hFFFFFFFF, div_by_zero=1 with done.
- div_by_zero is 0 with done for all other ops. It is cleared the cycle after done.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag.
- start while busy: ignored, and operands are not re-latched.
- hi_we/lo_we:
  - Honoured only in IDLE.
  - If asserted together with start, the write takes effect and the later result overwrites it.
  - Ignored in CALC and FINISH.
- hi/lo outputs hold their previous values throughout CALC and change only at FINISH, on a write, or on reset.
- op is latched at start; later changes to op are ignored.

Decomposition:
- Shared package mdu_pkg holds:
  - op encoding constants OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - state enum IDLE/CALC/FINISH
  - ITERS = DATA_W
- One module, no sub-module. The FSM and the 64-bit shift datapath are tightly coupled. The absolute-value and negate logic is a local function.

Test Plan:
1. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly E0..E32.
2. MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU rs=100, rt=0 -> hi=100, lo=0xFFFFFFFF, div_by_zero=1 for one cycle; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
4. Start MULTU 3*5, then pulse start with op=DIVU and new operands at E10 -> the second start is ignored; result hi=0, lo=15; done pulses once.
5. hi_we=1, wdata=0x1234 in IDLE -> hi=0x1234 next cycle; hi_we during CALC -> hi unchanged; lo_we together with start -> lo=wdata, then overwritten at done.
6. Assert reset=0 at E10 of a DIV -> after that edge busy=0, hi=lo=0, and no done pulse; a new MULTU 2*2 then gives lo=4 normally.
